exec_unit: RTL and testbench
============================

# exec_unit

Multicycle execute stage that sits directly upstream of the 4-entry, 32-bit register file. It accepts one instruction at a time over a valid/ready handshake and drives the register file's two read ports. It latches the operands, computes the result (single-cycle ALU ops, or an iterative shift-add multiply) and writes the result back through the register file's write port.

## Interface
- WORD_SIZE, 32: datapath width
- ADDR_W, 2: register address width (4 registers)
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- in_valid  in  1  instruction present
- in_ready  out  1  unit can accept an instruction
- in_op  in  3  opcode
- in_rs1, in_rs2  in  ADDR_W  source registers
- in_rd  in  ADDR_W  destination register
- rf_addr1, rf_addr2  out  ADDR_W  register file read addresses
- rf_data1, rf_data2  in  WORD_SIZE  register file read data (combinational from address)
- rf_addr3  out  ADDR_W  write address
- rf_data3  out  WORD_SIZE  write data
- rf_wr  out  1  write enable, one-cycle pulse
- done  out  1  one-cycle pulse, instruction retired
- busy  out  1  high in any state other than IDLE

## Operation
- Opcodes:
  - 000 ADD, 001 SUB (rs1−rs2), 010 AND, 011 OR, 100 XOR.
  - 101 SLT: signed compare; the result is 1 or 0, zero-extended.
  - 110 MUL: low WORD_SIZE bits of the unsigned product.
  - 111 NOP: no writeback.
- Arithmetic is modulo 2^WORD_SIZE; carries and overflow are discarded; no flags.
- FSM states: IDLE, READ, MUL, WB.
  - IDLE: in_ready=1. When in_valid && in_ready at the clock edge, capture op, rs1, rs2 and rd, then go to READ.
  - READ: rf_addr1/2 = captured rs1/rs2. At the edge, latch rf_data1/2 into A/B.
    - For a non-MUL op, register the result and go to WB.
    - For MUL, clear the accumulator and counter and go to MUL.
  - MUL: each cycle, if B[0] then acc += A; then A <<= 1, B >>= 1, count++. After exactly WORD_SIZE iterations, go to WB. No early exit.
  - WB: rf_addr3 = rd, rf_data3 = result, rf_wr = 1 (0 for NOP), done = 1. Go to IDLE.
- rf_addr1/2 hold their captured values outside READ. rf_addr3 and rf_data3 hold their last values.
- Inputs other than in_valid are ignored when no handshake occurs.

## Timing
- Accept edge = cycle 0.
- Non-MUL ops:
  - READ in cycle 1, WB in cycle 2.
  - The write commits at the end of cycle 2.
  - in_ready is high again in cycle 3.
  - Throughput is 1 instruction per 3 cycles.
- MUL:
  - READ in cycle 1, MUL in cycles 2..WORD_SIZE+1, WB in cycle WORD_SIZE+2 (cycle 34 at default).
- Read-after-write: the write commits before the next instruction's READ, so no forwarding is needed.
- Reset values, and outputs while rst=0: state=IDLE, in_ready=0, rf_wr=0, done=0, busy=0, and all address/data outputs are 0.
- Reset mid-operation: the instruction is aborted with no rf_wr pulse. in_ready rises in the first cycle after rst returns to 1.
- in_ready is a function of state and rst only, with no combinational path from in_valid.

## Configuration
- EXEC_MUL_EN defined: the MUL opcode is implemented as described, including the multiplier datapath and counter.
- EXEC_MUL_EN undefined:
  - The multiplier and MUL state are not built.
  - Opcode 110 behaves as NOP: 2-cycle path to WB, done=1, rf_wr=0.

## Structure
- Package exec_pkg holds:
  - opcode constants (OP_ADD … OP_NOP)
  - FSM state encoding
  - the WORD_SIZE default
- Sub-module exec_mul holds the iterative shift-add multiplier:
  - ports: start, a, b, busy, done, product
  - instantiated only under EXEC_MUL_EN
- ALU ops stay inline in exec_unit.

## Test plan
- Reset: hold rst=0 for 2 cycles with in_valid=1 → in_ready=0, rf_wr=0, done=0, busy=0; in_ready=1 in the first cycle after release.
- ADD with r0=5, r1=7, rd=2 → rf_wr pulse in cycle 2 with rf_addr3=2, rf_data3=12, done=1; in_ready=1 in cycle 3.
- SUB r=3 minus r=5 → 0xFFFFFFFE. SLT with 0xFFFFFFFF vs 1 → 1. XOR 0xF0F0F0F0 ^ 0xFFFF0000 → 0x0F0FF0F0.
- MUL 0x00010000 × 0x00010003 → rf_data3=0x00030000. rf_wr asserts exactly 34 cycles after accept; in_ready=0 and busy=1 throughout. Without EXEC_MUL_EN, the same op gives rf_wr=0 and done in cycle 2.
- Back-to-back with r1=3: ADD r1=r1+r1, then ADD r2=r1+r1 presented with in_valid held high → r1=6, then r2=12.
- Drive rst=0 during MUL iteration 10 → no rf_wr or done pulse. A following ADD completes normally in 3 cycles.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared constants for the exec_unit execute stage: widths, opcodes and FSM encoding.
// The optional multiplier is selected with the EXEC_MUL_EN macro.
package exec_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned ADDR_W    = 2;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned ST_W      = 2;

  localparam logic [OP_W-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W-1:0] OP_AND = 3'b010;
  localparam logic [OP_W-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W-1:0] OP_SLT = 3'b101;
  localparam logic [OP_W-1:0] OP_MUL = 3'b110;
  localparam logic [OP_W-1:0] OP_NOP = 3'b111;

  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_READ = 2'd1;
  localparam logic [ST_W-1:0] ST_MUL  = 2'd2;
  localparam logic [ST_W-1:0] ST_WB   = 2'd3;

  // Ops whose single-cycle ALU result is written back from READ.
  function automatic logic op_is_alu(input logic [OP_W-1:0] op);
    return (op != OP_NOP) && (op != OP_MUL);
  endfunction

endpackage

// File: rtl/exec_mul.sv
// Iterative shift-add multiplier: one partial product per cycle, WORD_SIZE cycles per product.
// done/product are valid during the final iteration so the caller can register the result on that edge.
module exec_mul
  import exec_pkg::*;
#(
  parameter int unsigned W = WORD_SIZE
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] product
);

  localparam int unsigned CNT_W = $clog2(W);

  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     acc_q;
  logic [W-1:0]     acc_nxt;
  logic [CNT_W-1:0] cnt_q;

  always_comb begin
    acc_nxt = acc_q + (b_q[0] ? a_q : '0);
  end

  assign done    = busy && (cnt_q == CNT_W'(W - 1));
  assign product = acc_nxt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      a_q   <= '0;
      b_q   <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      a_q   <= a;
      b_q   <= b;
      acc_q <= '0;
      cnt_q <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      acc_q <= acc_nxt;
      a_q   <= a_q << 1;
      b_q   <= b_q >> 1;
      cnt_q <= cnt_q + CNT_W'(1);
      if (done) busy <= 1'b0;
    end
  end

endmodule

// File: rtl/exec_unit.sv
// Multicycle execute stage in front of the 4-entry register file: read, compute, write back.
// Define EXEC_MUL_EN to build the shift-add multiplier; otherwise opcode MUL retires as a NOP.
module exec_unit
  import exec_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [OP_W-1:0]      in_op,
  input  logic [ADDR_W-1:0]    in_rs1,
  input  logic [ADDR_W-1:0]    in_rs2,
  input  logic [ADDR_W-1:0]    in_rd,
  output logic [ADDR_W-1:0]    rf_addr1,
  output logic [ADDR_W-1:0]    rf_addr2,
  input  logic [WORD_SIZE-1:0] rf_data1,
  input  logic [WORD_SIZE-1:0] rf_data2,
  output logic [ADDR_W-1:0]    rf_addr3,
  output logic [WORD_SIZE-1:0] rf_data3,
  output logic                 rf_wr,
  output logic                 done,
  output logic                 busy
);

  logic [ST_W-1:0]      state;
  logic [ST_W-1:0]      state_nxt;
  logic [OP_W-1:0]      op_q;
  logic [OP_W-1:0]      op_nxt;
  logic [ADDR_W-1:0]    rd_q;
  logic [ADDR_W-1:0]    rd_nxt;
  logic [ADDR_W-1:0]    addr1_nxt;
  logic [ADDR_W-1:0]    addr2_nxt;
  logic [ADDR_W-1:0]    addr3_nxt;
  logic [WORD_SIZE-1:0] data3_nxt;
  logic [WORD_SIZE-1:0] alu_res;
  logic                 wr_nxt;
  logic                 done_nxt;

  // Single-cycle ALU, fed straight from the register file read ports during READ
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  alu_res = rf_data1 + rf_data2;
      OP_SUB:  alu_res = rf_data1 - rf_data2;
      OP_AND:  alu_res = rf_data1 & rf_data2;
      OP_OR:   alu_res = rf_data1 | rf_data2;
      OP_XOR:  alu_res = rf_data1 ^ rf_data2;
      OP_SLT:  alu_res = {{(WORD_SIZE-1){1'b0}}, ($signed(rf_data1) < $signed(rf_data2))};
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_MUL_EN
  logic                 mul_start;
  logic                 mul_busy;
  logic                 mul_done;
  logic [WORD_SIZE-1:0] mul_product;

  exec_mul #(.W(WORD_SIZE)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (rf_data1),
    .b       (rf_data2),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );
`endif

  // Next-state and next-output logic
  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    rd_nxt    = rd_q;
    addr1_nxt = rf_addr1;
    addr2_nxt = rf_addr2;
    addr3_nxt = rf_addr3;
    data3_nxt = rf_data3;
    wr_nxt    = 1'b0;
    done_nxt  = 1'b0;
`ifdef EXEC_MUL_EN
    mul_start = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          op_nxt    = in_op;
          rd_nxt    = in_rd;
          addr1_nxt = in_rs1;
          addr2_nxt = in_rs2;
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
`ifdef EXEC_MUL_EN
        if (op_q == OP_MUL) begin
          mul_start = 1'b1;
          state_nxt = ST_MUL;
        end else
`endif
        begin
          state_nxt = ST_WB;
          done_nxt  = 1'b1;
          if (op_is_alu(op_q)) begin
            wr_nxt    = 1'b1;
            addr3_nxt = rd_q;
            data3_nxt = alu_res;
          end
        end
      end
`ifdef EXEC_MUL_EN
      ST_MUL: begin
        if (mul_done) begin
          state_nxt = ST_WB;
          done_nxt  = 1'b1;
          wr_nxt    = 1'b1;
          addr3_nxt = rd_q;
          data3_nxt = mul_product;
        end else if (!mul_busy) begin
          // Multiplier lost its operation without finishing; drop the instruction
          state_nxt = ST_IDLE;
        end
      end
`endif
      ST_WB: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      rf_addr1 <= '0;
      rf_addr2 <= '0;
      rf_addr3 <= '0;
      rf_data3 <= '0;
      rf_wr    <= 1'b0;
      done     <= 1'b0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_nxt;
      op_q     <= op_nxt;
      rd_q     <= rd_nxt;
      rf_addr1 <= addr1_nxt;
      rf_addr2 <= addr2_nxt;
      rf_addr3 <= addr3_nxt;
      rf_data3 <= data3_nxt;
      rf_wr    <= wr_nxt;
      done     <= done_nxt;
      in_ready <= (state_nxt == ST_IDLE);
      busy     <= (state_nxt != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit with a behavioural register file and reference model.
// Expected MUL behaviour follows the EXEC_MUL_EN macro.
module tb_exec_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_op;
  logic [1:0]  in_rs1, in_rs2, in_rd;
  logic [1:0]  rf_addr1, rf_addr2, rf_addr3;
  logic [31:0] rf_data1, rf_data2, rf_data3;
  logic        rf_wr, done, busy;

  logic [31:0] rf [4];
  logic [31:0] model [4];
  logic        ld_en;
  logic [1:0]  ld_a;
  logic [31:0] ld_d;

  int n_cmp = 0;
  int n_err = 0;

`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  always #5 clk = ~clk;

  exec_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .rf_addr1(rf_addr1), .rf_addr2(rf_addr2), .rf_data1(rf_data1), .rf_data2(rf_data2),
    .rf_addr3(rf_addr3), .rf_data3(rf_data3), .rf_wr(rf_wr), .done(done), .busy(busy)
  );

  // Register file: combinational reads, write at clock edge; ld_* preloads while the DUT is idle
  assign rf_data1 = rf[rf_addr1];
  assign rf_data2 = rf[rf_addr2];
  always @(posedge clk) begin
    if (rf_wr === 1'b1) rf[rf_addr3] <= rf_data3;
    else if (ld_en) rf[ld_a] <= ld_d;
  end

  function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: begin p = 64'(a) * 64'(b); return p[31:0]; end
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_writes(input logic [2:0] op);
    return (op != 3'd7) && (op != 3'd6 || MUL_EN);
  endfunction

  function automatic int ref_latency(input logic [2:0] op);
    return (op == 3'd6 && MUL_EN) ? 34 : 2;
  endfunction

  task automatic set_reg(input logic [1:0] a, input logic [31:0] v);
    ld_en = 1'b1; ld_a = a; ld_d = v;
    @(posedge clk); #1;
    ld_en = 1'b0;
    model[a] = v;
  endtask

  // Issue one instruction and observe it to retirement (stimulus/observation only)
  task automatic exec_instr(input logic [2:0] op, input logic [1:0] s1, input logic [1:0] s2,
                            input logic [1:0] d, output int dcyc, output int wcnt,
                            output logic [1:0] a3, output logic [31:0] d3,
                            output logic held, output logic rdy_after);
    int w;
    w = 0;
    while (in_ready !== 1'b1 && w < 50) begin @(posedge clk); #1; w++; end
    in_valid = 1'b1; in_op = op; in_rs1 = s1; in_rs2 = s2; in_rd = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_op = 3'($urandom); in_rs1 = 2'($urandom); in_rs2 = 2'($urandom); in_rd = 2'($urandom);
    dcyc = -1; wcnt = 0; held = 1'b1; a3 = 'x; d3 = 'x; rdy_after = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) held = 1'b0;
      if (rf_wr === 1'b1) wcnt++;
      if (done === 1'b1) begin dcyc = c; a3 = rf_addr3; d3 = rf_data3; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    rdy_after = in_ready;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_op = 3'd0; in_rs1 = 2'd0; in_rs2 = 2'd1; in_rd = 2'd2;
    for (int c = 0; c < 2; c++) begin
      @(posedge clk); #1;
      n_cmp++;
      if ({in_ready, rf_wr, done, busy} !== 4'b0000) begin
        n_err++;
        $display("FAIL reset_ctrl cycle %0d: ready/wr/done/busy=%b expected 0000", c, {in_ready, rf_wr, done, busy});
      end
      n_cmp++;
      if ({rf_addr1, rf_addr2, rf_addr3, rf_data3} !== 38'd0) begin
        n_err++;
        $display("FAIL reset_outputs cycle %0d: addrs/data=%h expected 0", c, {rf_addr1, rf_addr2, rf_addr3, rf_data3});
      end
    end
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL reset_release_ready: got %b expected 1", in_ready);
    end
    for (int i = 0; i < 4; i++) set_reg(2'(i), 32'd0);
  endtask

  task automatic test_add();
    int dcyc, wcnt; logic [1:0] a3; logic [31:0] d3; logic held, rdy;
    set_reg(2'd0, 32'd5); set_reg(2'd1, 32'd7);
    exec_instr(3'd0, 2'd0, 2'd1, 2'd2, dcyc, wcnt, a3, d3, held, rdy);
    n_cmp++;
    if (dcyc != 2 || wcnt != 1) begin
      n_err++; $display("FAIL add_timing: done cycle %0d writes %0d expected cycle 2 writes 1", dcyc, wcnt);
    end
    n_cmp++;
    if (a3 !== 2'd2 || d3 !== 32'd12) begin
      n_err++; $display("FAIL add_result: rd=%0d data=%h expected rd=2 data=0000000c", a3, d3);
    end
    n_cmp++;
    if (rdy !== 1'b1 || held !== 1'b1) begin
      n_err++; $display("FAIL add_ready: ready in cycle 3=%b busy-held=%b expected 1/1", rdy, held);
    end
    model[2] = 32'd12;
  endtask

  task automatic test_alu_directed();
    int dcyc, wcnt; logic [1:0] a3; logic [31:0] d3; logic held, rdy;
    logic [2:0]  ops [3] = '{3'd1, 3'd5, 3'd4};
    logic [31:0] va  [3] = '{32'd3, 32'hFFFF_FFFF, 32'hF0F0_F0F0};
    logic [31:0] vb  [3] = '{32'd5, 32'd1, 32'hFFFF_0000};
    logic [31:0] exp [3] = '{32'hFFFF_FFFE, 32'd1, 32'h0F0F_F0F0};
    for (int i = 0; i < 3; i++) begin
      set_reg(2'd0, va[i]); set_reg(2'd1, vb[i]);
      exec_instr(ops[i], 2'd0, 2'd1, 2'd3, dcyc, wcnt, a3, d3, held, rdy);
      n_cmp++;
      if (dcyc != 2 || wcnt != 1 || a3 !== 2'd3 || d3 !== exp[i]) begin
        n_err++;
        $display("FAIL alu_op%0d: cycle %0d writes %0d rd=%0d data=%h expected cycle 2 writes 1 rd=3 data=%h",
                 ops[i], dcyc, wcnt, a3, d3, exp[i]);
      end
      model[3] = exp[i];
    end
  endtask

  task automatic test_mul();
    int dcyc, wcnt; logic [1:0] a3; logic [31:0] d3; logic held, rdy;
    set_reg(2'd0, 32'h0001_0000); set_reg(2'd1, 32'h0001_0003);
    exec_instr(3'd6, 2'd0, 2'd1, 2'd2, dcyc, wcnt, a3, d3, held, rdy);
    n_cmp++;
    if (dcyc != (MUL_EN ? 34 : 2) || wcnt != (MUL_EN ? 1 : 0)) begin
      n_err++;
      $display("FAIL mul_timing: done cycle %0d writes %0d expected cycle %0d writes %0d",
               dcyc, wcnt, MUL_EN ? 34 : 2, MUL_EN ? 1 : 0);
    end
    n_cmp++;
    if (held !== 1'b1 || rdy !== 1'b1) begin
      n_err++; $display("FAIL mul_busy: busy-held=%b ready-after=%b expected 1/1", held, rdy);
    end
    if (MUL_EN) begin
      n_cmp++;
      if (a3 !== 2'd2 || d3 !== 32'h0003_0000) begin
        n_err++; $display("FAIL mul_result: rd=%0d data=%h expected rd=2 data=00030000", a3, d3);
      end
      model[2] = 32'h0003_0000;
    end
  endtask

  task automatic test_back_to_back();
    int wc [$]; logic [1:0] wa [$]; logic [31:0] wd [$];
    set_reg(2'd1, 32'd3);
    in_valid = 1'b1; in_op = 3'd0; in_rs1 = 2'd1; in_rs2 = 2'd1; in_rd = 2'd1;
    @(posedge clk); #1;
    in_rd = 2'd2;
    for (int c = 1; c <= 8; c++) begin
      if (rf_wr === 1'b1) begin wc.push_back(c); wa.push_back(rf_addr3); wd.push_back(rf_data3); end
      if (c == 3) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: cycle 3 ready=%b expected 1", in_ready); end
      end
      if (c == 4) in_valid = 1'b0;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (wc.size() != 2) begin
      n_err++; $display("FAIL b2b_count: writes %0d expected 2", wc.size());
    end else begin
      n_cmp++;
      if (wc[0] != 2 || wa[0] !== 2'd1 || wd[0] !== 32'd6 || wc[1] != 5 || wa[1] !== 2'd2 || wd[1] !== 32'd12) begin
        n_err++;
        $display("FAIL b2b_writes: (%0d,r%0d,%h) (%0d,r%0d,%h) expected (2,r1,00000006) (5,r2,0000000c)",
                 wc[0], wa[0], wd[0], wc[1], wa[1], wd[1]);
      end
    end
    model[1] = 32'd6; model[2] = 32'd12;
  endtask

  task automatic test_reset_mid_mul();
    int nw, nd, dcyc, wcnt; logic [1:0] a3; logic [31:0] d3; logic held, rdy;
    set_reg(2'd0, 32'd9); set_reg(2'd1, 32'd11);
    in_valid = 1'b1; in_op = 3'd6; in_rs1 = 2'd0; in_rs2 = 2'd1; in_rd = 2'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    nw = 0; nd = 0;
    for (int c = 1; c <= 40; c++) begin
      if (rf_wr === 1'b1) nw++;
      if (done === 1'b1) nd++;
      if (c == 12) begin
        n_cmp++;
        if ({busy, in_ready, rf_wr, done} !== 4'b0000 || rf_addr3 !== 2'd0 || rf_data3 !== 32'd0) begin
          n_err++;
          $display("FAIL abort_state: busy/ready/wr/done=%b rd=%0d data=%h expected 0000 0 0",
                   {busy, in_ready, rf_wr, done}, rf_addr3, rf_data3);
        end
        rst = 1'b1;
      end
      if (c == 13) begin
        n_cmp++;
        if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_ready: got %b expected 1", in_ready); end
      end
      if (c == 11) rst = 1'b0;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (nw != 0 || nd != (MUL_EN ? 0 : 1)) begin
      n_err++; $display("FAIL abort_pulses: writes %0d dones %0d expected 0/%0d", nw, nd, MUL_EN ? 0 : 1);
    end
    // Sync reset wipes nothing in the register file, only the DUT outputs
    exec_instr(3'd0, 2'd0, 2'd1, 2'd3, dcyc, wcnt, a3, d3, held, rdy);
    n_cmp++;
    if (dcyc != 2 || wcnt != 1 || a3 !== 2'd3 || d3 !== 32'd20 || rdy !== 1'b1) begin
      n_err++;
      $display("FAIL post_abort_add: cycle %0d writes %0d rd=%0d data=%h ready=%b expected 2 1 3 00000014 1",
               dcyc, wcnt, a3, d3, rdy);
    end
    model[3] = 32'd20;
  endtask

  task automatic test_random();
    int dcyc, wcnt; logic [1:0] a3; logic [31:0] d3; logic held, rdy;
    logic [2:0] op; logic [1:0] s1, s2, d; logic [31:0] exp;
    for (int n = 0; n < 30; n++) begin
      if ($urandom_range(0, 2) == 0)
        set_reg(2'($urandom), ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 20)) - 32'd10 : 32'($urandom));
      op = 3'($urandom); s1 = 2'($urandom); s2 = 2'($urandom); d = 2'($urandom);
      exp = ref_result(op, model[s1], model[s2]);
      exec_instr(op, s1, s2, d, dcyc, wcnt, a3, d3, held, rdy);
      n_cmp++;
      if (dcyc != ref_latency(op) || wcnt != (ref_writes(op) ? 1 : 0) || held !== 1'b1 || rdy !== 1'b1) begin
        n_err++;
        $display("FAIL rand%0d_op%0d_timing: cycle %0d writes %0d held %b ready %b expected %0d %0d 1 1",
                 n, op, dcyc, wcnt, held, rdy, ref_latency(op), ref_writes(op) ? 1 : 0);
      end
      if (ref_writes(op)) begin
        n_cmp++;
        if (a3 !== d || d3 !== exp) begin
          n_err++;
          $display("FAIL rand%0d_op%0d_result: rd=%0d data=%h expected rd=%0d data=%h", n, op, a3, d3, d, exp);
        end
        model[d] = exp;
      end
    end
  endtask

  task automatic test_regfile();
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if (rf[i] !== model[i]) begin
        n_err++; $display("FAIL regfile_r%0d: got %h expected %h", i, rf[i], model[i]);
      end
    end
  endtask

  initial begin
    ld_en = 1'b0; ld_a = 2'd0; ld_d = 32'd0;
    test_reset();
    test_add();
    test_alu_directed();
    test_mul();
    test_back_to_back();
    test_reset_mid_mul();
    test_random();
    test_regfile();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
